// File: rtl/qpsk_slicer_ber_pkg.sv
//==============================================================================
// Module   : qpsk_slicer_ber_pkg
// Brief    : Shared FSM encoding, QPSK bit mapping and popcount helper for the
//            receive-side QPSK slicer / BER counter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package qpsk_slicer_ber_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Bit positions in {b1,b0}: b1 carries the I sign, b0 the Q sign.
    localparam int c_B1_IDX = 1;
    localparam int c_B0_IDX = 0;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/qpsk_slicer_ber_sync_fifo.sv
//==============================================================================
// Module   : qpsk_slicer_ber_sync_fifo
// Brief    : Single-clock FIFO with full/empty flags, synchronous reset and a
//            synchronous clear. A push into a full FIFO lands only with a pop.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module qpsk_slicer_ber_sync_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign rdata     = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !rst && !clr) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/qpsk_slicer_ber.sv
//==============================================================================
// Module   : qpsk_slicer_ber
// Brief    : Hard QPSK slicer comparing decisions against buffered transmitted
//            bits; counts symbols and saturating bit errors over a run.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module qpsk_slicer_ber
    import qpsk_slicer_ber_pkg::*;
#(
    parameter int W          = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_symbols,
    input  logic             ref_valid,
    input  logic [1:0]       ref_bits,
    input  logic             in_valid,
    input  logic [W-1:0]     Y_in_real,
    input  logic [W-1:0]     Y_in_imag,
    output logic             bits_valid,
    output logic [1:0]       bits_out,
    output logic [CNT_W-1:0] symbol_count,
    output logic [CNT_W-1:0] bit_errors,
    output logic             done,
    output logic             overflow,
    output logic             underflow
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_sym;
    logic [CNT_W-1:0] r_err;
    logic [CNT_W-1:0] w_sym_nxt;
    logic [CNT_W-1:0] w_err_nxt;
    logic [CNT_W:0]   w_err_sum;
    logic             r_bits_valid;
    logic [1:0]       r_bits;
    logic             r_ovf;
    logic             r_udf;
    logic [1:0]       w_dec;
    logic [1:0]       w_head;
    logic [1:0]       w_nerr;
    logic             w_run;
    logic             w_push;
    logic             w_cmp;
    logic             w_full;
    logic             w_empty;
    logic             w_unused_lsbs;

    assign w_run  = (r_state == c_ST_RUN);
    // start wins over any same-cycle traffic: the FIFO is being cleared.
    assign w_push = w_run && ref_valid && !start;
    assign w_cmp  = w_run && in_valid && !w_empty && !start;

    qpsk_slicer_ber_sync_fifo #(
        .WIDTH (2),
        .DEPTH (FIFO_DEPTH)
    ) u_ref_fifo (
        .clk   (clk),
        .rst   (reset),
        .clr   (start),
        .push  (w_push),
        .pop   (w_cmp),
        .wdata (ref_bits),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_dec           = '0;
        w_dec[c_B1_IDX] = Y_in_real[W-1];
        w_dec[c_B0_IDX] = Y_in_imag[W-1];
    end

    assign w_unused_lsbs = ^{Y_in_real[W-2:0], Y_in_imag[W-2:0]};

    assign w_nerr    = popcount2(w_dec ^ w_head);
    assign w_sym_nxt = r_sym + CNT_W'(1);
    assign w_err_sum = {1'b0, r_err} + (CNT_W+1)'(w_nerr);
    assign w_err_nxt = w_err_sum[CNT_W] ? {CNT_W{1'b1}} : w_err_sum[CNT_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = (num_symbols != '0) ? c_ST_RUN : c_ST_DONE;
        end else if (w_cmp && (w_sym_nxt == r_num)) begin
            w_state_nxt = c_ST_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_num        <= '0;
            r_sym        <= '0;
            r_err        <= '0;
            r_bits_valid <= 1'b0;
            r_bits       <= '0;
            r_ovf        <= 1'b0;
            r_udf        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bits_valid <= w_cmp;
            if (w_cmp) r_bits <= w_dec;
            if (start) begin
                r_num <= num_symbols;
                r_sym <= '0;
                r_err <= '0;
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end else if (w_run) begin
                if (w_cmp) begin
                    r_sym <= w_sym_nxt;
                    r_err <= w_err_nxt;
                end
                if (in_valid && w_empty) r_udf <= 1'b1;
                if (ref_valid && w_full && !w_cmp) r_ovf <= 1'b1;
            end
        end
    end

    assign bits_valid   = r_bits_valid;
    assign bits_out     = r_bits;
    assign symbol_count = r_sym;
    assign bit_errors   = r_err;
    assign done         = (r_state == c_ST_DONE);
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

`default_nettype wire

// File: tb/tb_qpsk_slicer_ber.sv
//==============================================================================
// Module   : tb_qpsk_slicer_ber
// Brief    : Self-checking bench for qpsk_slicer_ber with a queue-based model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_qpsk_slicer_ber;

    localparam int W  = 16;
    localparam int FD = 16;
    localparam int CW = 32;
    localparam longint c_MAX = 64'h0000_0000_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset, start, ref_valid, in_valid;
    logic [CW-1:0] num_symbols;
    logic [1:0]    ref_bits;
    logic [W-1:0]  y_re, y_im;
    logic          bits_valid, done, overflow, underflow;
    logic [1:0]    bits_out;
    logic [CW-1:0] symbol_count, bit_errors;
    logic [69:0]   dut_vec;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [1:0] m_q[$];
    int         m_state;
    longint     m_num, m_sym, m_err;
    bit         m_bv, m_ov, m_uf;
    logic [1:0] m_bits;

    logic [1:0] s_ref[$];
    int         s_re[$], s_im[$];
    logic [1:0] got_bits[$];

    always #5 clk = ~clk;

    qpsk_slicer_ber #(.W(W), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_symbols  (num_symbols),
        .ref_valid    (ref_valid),
        .ref_bits     (ref_bits),
        .in_valid     (in_valid),
        .Y_in_real    (y_re),
        .Y_in_imag    (y_im),
        .bits_valid   (bits_valid),
        .bits_out     (bits_out),
        .symbol_count (symbol_count),
        .bit_errors   (bit_errors),
        .done         (done),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    assign dut_vec = {bits_valid, bits_out, done, overflow, underflow, symbol_count, bit_errors};

    function automatic logic [69:0] exp_vec();
        return {m_bv, m_bits, (m_state == 2), m_ov, m_uf, 32'(m_sym), 32'(m_err)};
    endfunction

    function automatic int amp(input logic b, input int a);
        return b ? -a : a;
    endfunction

    task automatic model_edge();
        logic [1:0] head, dec;
        bit         pop_ok;
        int         d;
        if (reset) begin
            m_q.delete(); m_state = 0; m_num = 0; m_sym = 0; m_err = 0;
            m_bv = 0; m_bits = 2'b00; m_ov = 0; m_uf = 0;
        end else if (start) begin
            m_q.delete(); m_sym = 0; m_err = 0; m_ov = 0; m_uf = 0; m_bv = 0;
            m_num   = num_symbols;
            m_state = (num_symbols == 0) ? 2 : 1;
        end else if (m_state == 1) begin
            pop_ok = in_valid && (m_q.size() > 0);
            m_bv   = pop_ok;
            if (in_valid && m_q.size() == 0) m_uf = 1;
            head = pop_ok ? m_q.pop_front() : 2'b00;
            if (ref_valid) begin
                if (m_q.size() < FD) m_q.push_back(ref_bits);
                else m_ov = 1;
            end
            if (pop_ok) begin
                dec[1] = ($signed(y_re) < 0);
                dec[0] = ($signed(y_im) < 0);
                m_bits = dec;
                d = int'(dec[1] != head[1]) + int'(dec[0] != head[0]);
                m_err = (m_err + d > c_MAX) ? c_MAX : m_err + d;
                m_sym = m_sym + 1;
                if (m_sym == m_num) m_state = 2;
            end
        end else begin
            m_bv = 0;
        end
    endtask

    task automatic cycle(input bit rs, input bit st, input logic [CW-1:0] n, input bit rv,
                         input logic [1:0] rb, input bit iv, input int re, input int im);
        reset = rs; start = st; num_symbols = n; ref_valid = rv; ref_bits = rb;
        in_valid = iv; y_re = W'(re); y_im = W'(im);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Push s_ref, then feed s_re/s_im 'lat' cycles later, collecting decisions.
    task automatic run_seq(input int lat);
        int n, k;
        bit rv, iv;
        n = s_ref.size();
        got_bits.delete();
        for (int t = 0; t < n + lat; t++) begin
            rv = (t < n);
            k  = t - lat;
            iv = (k >= 0) && (k < n);
            cycle(0, 0, '0, rv, rv ? s_ref[t] : 2'b00, iv, iv ? s_re[k] : 0, iv ? s_im[k] : 0);
            if (bits_valid) got_bits.push_back(bits_out);
        end
    endtask

    task automatic test_reset();
        cycle(1, 0, '0, 0, 2'b00, 0, 0, 0);
        cycle(1, 0, '0, 1, 2'b11, 1, -7, -7);
        checks++;
        if (dut_vec !== 70'b0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", dut_vec);
        end
        cycle(0, 0, '0, 1, 2'b01, 1, -9, 9);
        checks++;
        if (dut_vec !== 70'b0 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL idle_ignores_inputs: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_noise_free();
        cycle(0, 1, 32'd4, 0, 2'b00, 0, 0, 0);
        s_ref = '{2'd0, 2'd1, 2'd2, 2'd3};
        s_re  = '{100, 100, -100, -100};
        s_im  = '{100, -100, 100, -100};
        run_seq(3);
        checks++;
        if (got_bits.size() != 4) begin
            errors++; $display("FAIL nf_decision_count: got %0d want 4", got_bits.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got_bits[k] !== s_ref[k]) begin
                    errors++; $display("FAIL nf_bits[%0d]: got %b want %b", k, got_bits[k], s_ref[k]);
                end
            end
        end
        checks++;
        if (symbol_count !== 32'd4 || bit_errors !== 32'd0 || done !== 1'b1) begin
            errors++;
            $display("FAIL nf_final: got sym=%0d err=%0d done=%b want 4 0 1", symbol_count, bit_errors, done);
        end
    endtask

    task automatic test_errors();
        cycle(0, 1, 32'd3, 0, 2'b00, 0, 0, 0);
        s_ref = '{2'd0, 2'd0, 2'd0};
        s_re  = '{-5, -5, 5};
        s_im  = '{5, -5, 5};
        run_seq(1);
        checks++;
        if (bit_errors !== 32'd3 || symbol_count !== 32'd3 || done !== 1'b1) begin
            errors++;
            $display("FAIL err_counts: got err=%0d sym=%0d done=%b want 3 3 1", bit_errors, symbol_count, done);
        end
        checks++;
        if (got_bits.size() != 3 || got_bits[0] !== 2'b10 || got_bits[1] !== 2'b11 || got_bits[2] !== 2'b00) begin
            errors++; $display("FAIL err_decisions: got %0d decisions, first %b want 10,11,00",
                               got_bits.size(), got_bits.size() > 0 ? got_bits[0] : 2'bxx);
        end
    endtask

    task automatic test_edges();
        cycle(0, 1, 32'd2, 0, 2'b00, 0, 0, 0);
        s_ref = '{2'd0, 2'd2};
        s_re  = '{0, -32768};
        s_im  = '{0, 32767};
        run_seq(2);
        checks++;
        if (got_bits.size() != 2 || got_bits[0] !== 2'b00 || got_bits[1] !== 2'b10) begin
            errors++; $display("FAIL edge_decisions: got size %0d last %b want 00,10",
                               got_bits.size(), bits_out);
        end
        checks++;
        if (bit_errors !== 32'd0 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL edge_state: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_fifo();
        logic [1:0] b;
        cycle(0, 1, 32'd100, 0, 2'b00, 0, 0, 0);
        for (int k = 0; k < 16; k++) cycle(0, 0, '0, 1, 2'(k % 4), 0, 0, 0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL fifo_no_ovf_at_16: got %b want 0", overflow);
        end
        cycle(0, 0, '0, 1, 2'b11, 0, 0, 0);
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL fifo_ovf_at_17: got %b want 1", overflow);
        end
        for (int k = 0; k < 16; k++) begin
            b = 2'(k % 4);
            cycle(0, 0, '0, 0, 2'b00, 1, amp(b[1], 300), amp(b[0], 300));
        end
        checks++;
        if (symbol_count !== 32'd16 || bit_errors !== 32'd0 || underflow !== 1'b0) begin
            errors++; $display("FAIL fifo_drain: got sym=%0d err=%0d udf=%b want 16 0 0",
                               symbol_count, bit_errors, underflow);
        end
        cycle(0, 0, '0, 0, 2'b00, 1, 300, 300);
        checks++;
        if (underflow !== 1'b1 || symbol_count !== 32'd16 || bits_valid !== 1'b0) begin
            errors++; $display("FAIL fifo_udf: got udf=%b sym=%0d bv=%b want 1 16 0",
                               underflow, symbol_count, bits_valid);
        end
    endtask

    task automatic test_run_control();
        cycle(0, 1, 32'd0, 0, 2'b00, 0, 0, 0);
        checks++;
        if (done !== 1'b1 || symbol_count !== 32'd0 || bit_errors !== 32'd0) begin
            errors++; $display("FAIL rc_zero_run: got done=%b sym=%0d err=%0d want 1 0 0",
                               done, symbol_count, bit_errors);
        end
        cycle(0, 1, 32'd5, 0, 2'b00, 0, 0, 0);
        s_ref = '{2'd0, 2'd0};
        s_re  = '{-5, -5};
        s_im  = '{-5, -5};
        run_seq(1);
        checks++;
        if (symbol_count !== 32'd2 || bit_errors !== 32'd4 || done !== 1'b0) begin
            errors++; $display("FAIL rc_partial: got sym=%0d err=%0d done=%b want 2 4 0",
                               symbol_count, bit_errors, done);
        end
        cycle(0, 1, 32'd3, 1, 2'b01, 1, 5, 5);
        checks++;
        if (symbol_count !== 32'd0 || bit_errors !== 32'd0 || done !== 1'b0 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL rc_restart: got %h want %h", dut_vec, exp_vec());
        end
        cycle(0, 0, '0, 1, 2'b01, 0, 0, 0);
        cycle(0, 0, '0, 1, 2'b10, 1, 5, -5);
        cycle(1, 0, '0, 1, 2'b10, 1, 5, -5);
        checks++;
        if (dut_vec !== 70'b0) begin
            errors++; $display("FAIL rc_reset_midrun: got %h want 0", dut_vec);
        end
    endtask

    task automatic test_soak();
        localparam int c_N = 3000;
        localparam int c_A = 8000;
        localparam int c_S = 12000;
        int         cyc;
        bit         rv, iv;
        logic [1:0] rb, hb;
        cycle(0, 1, 32'(c_N), 0, 2'b00, 0, 0, 0);
        cyc = 0;
        while (m_state != 2 && cyc < 20000) begin
            rv = ($urandom_range(0, 99) < 50);
            iv = ($urandom_range(0, 99) < 50);
            rb = 2'($urandom_range(0, 3));
            hb = (m_q.size() > 0) ? m_q[0] : 2'($urandom_range(0, 3));
            cycle(0, 0, '0, rv, rb, iv,
                  amp(hb[1], c_A) + int'($urandom_range(0, 2 * c_S)) - c_S,
                  amp(hb[0], c_A) + int'($urandom_range(0, 2 * c_S)) - c_S);
            cyc++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL soak_cycle%0d: got %h want %h", cyc, dut_vec, exp_vec());
            end
        end
        checks++;
        if (done !== 1'b1 || symbol_count !== 32'(c_N) || bit_errors !== 32'(m_err)) begin
            errors++; $display("FAIL soak_final: got done=%b sym=%0d err=%0d want 1 %0d %0d",
                               done, symbol_count, bit_errors, c_N, m_err);
        end
    endtask

    initial begin
        test_reset();
        test_noise_free();
        test_errors();
        test_edges();
        test_fifo();
        test_run_control();
        test_soak();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
